// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag bit positions, register tag width and the
// result-queue entry layout used between the multiplier and writeback.
package alu_pkg;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_H = 1;
   localparam int FLAG_V = 0;

   localparam int RD_W = 5;

   typedef struct packed {
      logic [31:0]     data;
      logic [RD_W-1:0] rd;
   } mul_entry_t;

endpackage

// File: rtl/alu_sync_fifo.sv
// Single-clock valid/ready FIFO with occupancy count. Head is muxed from
// storage and forced to zero when empty; in_ready depends only on count.
module alu_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic [AW:0]   count
);

   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
   assign in_ready  = (count != FULL_CNT);
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign out_data  = out_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mul_result_stage.sv
// Registered stage after the 32x32 multiplier: queues {result, tag} for
// writeback and tracks the architectural flags plus a sticky overflow bit.
module mul_result_stage
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            InValid,
   output logic            InReady,
   input  logic [31:0]     InData,
   input  logic [3:0]      InFlags,
   input  logic            InS,
   input  logic [RD_W-1:0] InRd,
   output logic            OutValid,
   input  logic            OutReady,
   output logic [31:0]     OutData,
   output logic [RD_W-1:0] OutRd,
   output logic [3:0]      Flags,
   output logic            StickyV,
   input  logic            ClrSticky,
   output logic [AW:0]     Count
);

   mul_entry_t in_entry;
   mul_entry_t out_entry;
   logic       accept;
   logic       set_flags;

   assign in_entry.data = InData;
   assign in_entry.rd   = InRd;
   assign OutData       = out_entry.data;
   assign OutRd         = out_entry.rd;

   assign accept    = InValid & InReady;
   // InFlags may be X when InS=0, so every use is qualified by set_flags first.
   assign set_flags = accept & InS;

   alu_sync_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(mul_entry_t)),
      .AW    (AW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (InValid),
      .in_ready  (InReady),
      .in_data   (in_entry),
      .out_valid (OutValid),
      .out_ready (OutReady),
      .out_data  (out_entry),
      .count     (Count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Flags   <= 4'b0000;
         StickyV <= 1'b0;
      end else begin
         if (set_flags) Flags <= InFlags;
         // A setting overflow beats a same-cycle clear.
         if (set_flags && InFlags[FLAG_V]) StickyV <= 1'b1;
         else if (ClrSticky)              StickyV <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mul_result_stage.sv
// Directed self-checking bench for mul_result_stage: handshake, ordering,
// flag/sticky behaviour, streaming wrap-around and asynchronous reset.
module tb_mul_result_stage;

   logic        clk;
   logic        rst_n;
   logic        InValid;
   logic        InReady;
   logic [31:0] InData;
   logic [3:0]  InFlags;
   logic        InS;
   logic [4:0]  InRd;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] OutData;
   logic [4:0]  OutRd;
   logic [3:0]  Flags;
   logic        StickyV;
   logic        ClrSticky;
   logic [2:0]  Count;

   int tests;
   int fails;
   logic [36:0] exp_q[$];

   mul_result_stage #(.DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .InValid(InValid), .InReady(InReady), .InData(InData), .InFlags(InFlags),
      .InS(InS), .InRd(InRd),
      .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .OutRd(OutRd),
      .Flags(Flags), .StickyV(StickyV), .ClrSticky(ClrSticky), .Count(Count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver: present one entry from a negedge until it is accepted.
   task automatic push(input logic [31:0] d, input logic [4:0] rd,
                       input logic s, input logic [3:0] f);
      bit done;
      done    = 0;
      InValid = 1'b1; InData = d; InRd = rd; InS = s; InFlags = f;
      for (int n = 0; n < 20 && !done; n++) begin
         if (InReady) done = 1;
         @(negedge clk);
      end
      InValid = 1'b0; InS = 1'b0; InFlags = 4'b0000;
      if (!done) begin
         tests++; fails++;
         $display("FAIL push_timeout rd=%0d InReady never rose", rd);
      end
   endtask

   task automatic drain();
      OutReady = 1'b1;
      for (int n = 0; n < 20 && Count != 0; n++) @(negedge clk);
      OutReady = 1'b0;
      tests++;
      if (Count !== 3'd0) begin
         fails++; $display("FAIL drain_empty Count=%0d want 0", Count);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      InValid = 0; InData = 0; InFlags = 0; InS = 0; InRd = 0;
      OutReady = 0; ClrSticky = 0;
      repeat (2) @(negedge clk);
      tests++;
      if ({Count, OutValid, OutData, OutRd, Flags, StickyV} !== '0) begin
         fails++;
         $display("FAIL reset_outputs Count=%0d OutValid=%b OutData=%h OutRd=%0d Flags=%b StickyV=%b want all 0",
                  Count, OutValid, OutData, OutRd, Flags, StickyV);
      end
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (InReady !== 1'b1) begin
         fails++; $display("FAIL reset_inready InReady=%b want 1", InReady);
      end
   endtask

   task automatic test_basic();
      push(32'h0000_0006, 5'd3, 1'b1, 4'b0000);
      tests++;
      if (OutValid !== 1'b1 || OutData !== 32'd6 || OutRd !== 5'd3 || Flags !== 4'b0000 || Count !== 3'd1) begin
         fails++;
         $display("FAIL basic_latency OutValid=%b OutData=%h OutRd=%0d Flags=%b Count=%0d want 1/6/3/0000/1",
                  OutValid, OutData, OutRd, Flags, Count);
      end
      OutReady = 1'b1;
      @(negedge clk);
      OutReady = 1'b0;
      tests++;
      if (Count !== 3'd0 || OutValid !== 1'b0 || OutData !== 32'd0 || OutRd !== 5'd0) begin
         fails++;
         $display("FAIL basic_drain Count=%0d OutValid=%b OutData=%h OutRd=%0d want 0/0/0/0",
                  Count, OutValid, OutData, OutRd);
      end
   endtask

   task automatic test_fill();
      exp_q.delete();
      for (int i = 1; i <= 4; i++) begin
         push(32'h100 + i, i[4:0], 1'b0, 4'b0000);
         exp_q.push_back({32'h100 + i, i[4:0]});
      end
      tests++;
      if (Count !== 3'd4 || InReady !== 1'b0 || OutRd !== 5'd1) begin
         fails++;
         $display("FAIL fill_full Count=%0d InReady=%b OutRd=%0d want 4/0/1", Count, InReady, OutRd);
      end
      // Fifth request waits while the queue is full.
      InValid = 1'b1; InData = 32'h105; InRd = 5'd5; InS = 1'b0;
      @(negedge clk);
      tests++;
      if (Count !== 3'd4 || InReady !== 1'b0) begin
         fails++; $display("FAIL fill_hold Count=%0d InReady=%b want 4/0", Count, InReady);
      end
      OutReady = 1'b1;
      @(negedge clk);
      OutReady = 1'b0;
      void'(exp_q.pop_front());
      tests++;
      if (Count !== 3'd3 || InReady !== 1'b1 || OutRd !== 5'd2) begin
         fails++; $display("FAIL fill_reopen Count=%0d InReady=%b OutRd=%0d want 3/1/2", Count, InReady, OutRd);
      end
      @(negedge clk);
      InValid = 1'b0;
      exp_q.push_back({32'h105, 5'd5});
      tests++;
      if (Count !== 3'd4) begin
         fails++; $display("FAIL fill_fifth Count=%0d want 4", Count);
      end
      OutReady = 1'b1;
      for (int n = 0; n < 10 && exp_q.size() > 0; n++) begin
         tests++;
         if (OutValid !== 1'b1 || {OutData, OutRd} !== exp_q[0]) begin
            fails++;
            $display("FAIL fill_order OutValid=%b data=%h rd=%0d want data=%h rd=%0d",
                     OutValid, OutData, OutRd, exp_q[0][36:5], exp_q[0][4:0]);
         end
         void'(exp_q.pop_front());
         @(negedge clk);
      end
      OutReady = 1'b0;
      tests++;
      if (Count !== 3'd0 || exp_q.size() != 0) begin
         fails++; $display("FAIL fill_empty Count=%0d left=%0d want 0/0", Count, exp_q.size());
      end
   endtask

   task automatic test_flags_x();
      push(32'h1, 5'd7, 1'b1, 4'b1000);
      push(32'h2, 5'd8, 1'b0, 4'bxxxx);
      tests++;
      if (Flags !== 4'b1000 || StickyV !== 1'b0) begin
         fails++; $display("FAIL flags_hold Flags=%b StickyV=%b want 1000/0", Flags, StickyV);
      end
      drain();
   endtask

   task automatic test_sticky();
      push(32'h0, 5'd9, 1'b1, 4'b0001);
      tests++;
      if (StickyV !== 1'b1 || Flags !== 4'b0001) begin
         fails++; $display("FAIL sticky_set StickyV=%b Flags=%b want 1/0001", StickyV, Flags);
      end
      push(32'h4, 5'd10, 1'b1, 4'b0000);
      tests++;
      if (StickyV !== 1'b1 || Flags !== 4'b0000) begin
         fails++; $display("FAIL sticky_persist StickyV=%b Flags=%b want 1/0000", StickyV, Flags);
      end
      ClrSticky = 1'b1;
      @(negedge clk);
      ClrSticky = 1'b0;
      tests++;
      if (StickyV !== 1'b0) begin
         fails++; $display("FAIL sticky_clear StickyV=%b want 0", StickyV);
      end
      ClrSticky = 1'b1;
      push(32'h0, 5'd11, 1'b1, 4'b0001);
      ClrSticky = 1'b0;
      tests++;
      if (StickyV !== 1'b1) begin
         fails++; $display("FAIL sticky_set_wins StickyV=%b want 1", StickyV);
      end
      drain();
   endtask

   task automatic test_stream();
      exp_q.delete();
      push(32'hA000_0000, 5'd1, 1'b0, 4'b0000);
      push(32'hA000_0001, 5'd2, 1'b0, 4'b0000);
      exp_q.push_back({32'hA000_0000, 5'd1});
      exp_q.push_back({32'hA000_0001, 5'd2});
      OutReady = 1'b1;
      for (int i = 2; i < 22; i++) begin
         InValid = 1'b1; InData = 32'hA000_0000 + i; InRd = i[4:0]; InS = 1'b0;
         tests++;
         if (Count !== 3'd2 || OutValid !== 1'b1 || {OutData, OutRd} !== exp_q[0]) begin
            fails++;
            $display("FAIL stream_cycle%0d Count=%0d data=%h rd=%0d want 2 data=%h rd=%0d",
                     i, Count, OutData, OutRd, exp_q[0][36:5], exp_q[0][4:0]);
         end
         exp_q.push_back({InData, InRd});
         void'(exp_q.pop_front());
         @(negedge clk);
      end
      InValid = 1'b0;
      for (int n = 0; n < 10 && exp_q.size() > 0; n++) begin
         tests++;
         if ({OutData, OutRd} !== exp_q[0]) begin
            fails++;
            $display("FAIL stream_tail data=%h rd=%0d want data=%h rd=%0d",
                     OutData, OutRd, exp_q[0][36:5], exp_q[0][4:0]);
         end
         void'(exp_q.pop_front());
         @(negedge clk);
      end
      OutReady = 1'b0;
      tests++;
      if (Count !== 3'd0) begin
         fails++; $display("FAIL stream_empty Count=%0d want 0", Count);
      end
   endtask

   task automatic test_async_reset();
      push(32'h11, 5'd1, 1'b1, 4'b1001);
      push(32'h22, 5'd2, 1'b0, 4'b0000);
      push(32'h33, 5'd3, 1'b0, 4'b0000);
      tests++;
      if (Count !== 3'd3 || Flags !== 4'b1001 || StickyV !== 1'b1) begin
         fails++; $display("FAIL areset_pre Count=%0d Flags=%b StickyV=%b want 3/1001/1", Count, Flags, StickyV);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (Count !== 3'd0 || OutValid !== 1'b0 || Flags !== 4'b0000 || StickyV !== 1'b0) begin
         fails++;
         $display("FAIL areset_flush Count=%0d OutValid=%b Flags=%b StickyV=%b want 0/0/0000/0",
                  Count, OutValid, Flags, StickyV);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (InReady !== 1'b1 || Count !== 3'd0) begin
         fails++; $display("FAIL areset_release InReady=%b Count=%0d want 1/0", InReady, Count);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_basic();
      test_fill();
      test_flags_x();
      test_sticky();
      test_stream();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1);
   end

endmodule
